// File: rtl/mem_bus_fabric.sv
// mem_bus_fabric: decodes CPU requests onto NUM_SLAVES memory slaves, returns
// the selected slave's ready/read data, and answers unmapped or stalled
// accesses with an error response.
// Optional error capture (err_irq/err_addr) is built when the macro
// MEM_BUS_FABRIC_ERR_CAPTURE_EN is defined; otherwise those outputs are tied low.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// S_IDLE     | no transfer in flight, waiting for mem_valid
// S_ACCESS   | one slave selected, waiting for its ready or the timeout
// S_ERR_RESP | unmapped address; one quiet cycle, then a one-cycle error reply
module mem_bus_fabric #(
  parameter int                      NUM_SLAVES     = 8,
  parameter logic [NUM_SLAVES*32-1:0] SLV_BASE      = '0,
  parameter logic [NUM_SLAVES*32-1:0] SLV_MASK      = '0,
  parameter int                      TIMEOUT_CYCLES = 255,
  parameter logic [31:0]             ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mem_valid,
  input  logic [31:0]                mem_addr,
  input  logic [3:0]                 mem_wstrb,
  output logic                       mem_ready,
  output logic [31:0]                mem_rdata,
  output logic [NUM_SLAVES-1:0]      slv_sel,
  input  logic [NUM_SLAVES-1:0]      slv_ready,
  input  logic [NUM_SLAVES*32-1:0]   slv_rdata,
  output logic                       busy,
  output logic                       err_irq,
  output logic [31:0]                err_addr,
  input  logic                       err_clr
);

  // Counter holds 1..TIMEOUT_CYCLES during an access and saturates, so it never wraps.
  localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACCESS   = 2'd1,
    S_ERR_RESP = 2'd2
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic                    err_phase;
  logic                    hit;
  logic [NUM_SLAVES-1:0]   hit_sel;
  logic                    sel_ready;
  logic [31:0]             sel_rdata;
  logic                    timeout_hit;
  logic                    new_err;

  // Write strobes travel to the slaves outside this block.
  logic unused_wstrb;
  assign unused_wstrb = ^mem_wstrb;

  // Address decode; scanning downwards lets the lowest matching index win.
  always_comb begin
    hit     = 1'b0;
    hit_sel = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((mem_addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
        hit        = 1'b1;
        hit_sel    = '0;
        hit_sel[i] = 1'b1;
      end
    end
  end

  // Pick ready/data of the currently selected slave; others are ignored.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (slv_sel[i]) begin
        sel_ready = slv_ready[i];
        sel_rdata = slv_rdata[32*i +: 32];
      end
    end
  end

  assign timeout_hit = (state == S_ACCESS) && (cnt == CNT_MAX);

  // An error is either an unmapped request or a timeout that the slave did not beat.
  assign new_err = ((state == S_IDLE) && mem_valid && !hit) ||
                   ((state == S_ACCESS) && mem_valid && !sel_ready && timeout_hit);

  // Response path: slave ready is passed through combinationally; a ready that
  // coincides with the timeout is a normal completion. Reset suppresses any reply.
  always_comb begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    if (!reset) begin
      if (state == S_ACCESS && mem_valid) begin
        if (sel_ready) begin
          mem_ready = 1'b1;
          mem_rdata = sel_rdata;
        end else if (timeout_hit) begin
          mem_ready = 1'b1;
          mem_rdata = ERR_DATA;
        end
      end else if (state == S_ERR_RESP && err_phase) begin
        mem_ready = 1'b1;
        mem_rdata = ERR_DATA;
      end
    end
  end

  // Main FSM with registered select, busy and access counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      slv_sel   <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      err_phase <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mem_valid) begin
            busy <= 1'b1;
            if (hit) begin
              state   <= S_ACCESS;
              slv_sel <= hit_sel;
              cnt     <= CNT_ONE;
            end else begin
              state     <= S_ERR_RESP;
              err_phase <= 1'b0;
            end
          end
        end
        S_ACCESS: begin
          // Completion, timeout and abort all end the access the same way.
          if (!mem_valid || sel_ready || timeout_hit) begin
            state   <= S_IDLE;
            slv_sel <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_ERR_RESP: begin
          if (err_phase) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            err_phase <= 1'b0;
          end else begin
            err_phase <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          slv_sel   <= '0;
          cnt       <= '0;
          busy      <= 1'b0;
          err_phase <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEM_BUS_FABRIC_ERR_CAPTURE_EN
  // Sticky error capture; a new error wins over a coincident clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_irq  <= 1'b0;
      err_addr <= '0;
    end else if (new_err && (!err_irq || err_clr)) begin
      err_irq  <= 1'b1;
      err_addr <= mem_addr;
    end else if (err_clr) begin
      err_irq  <= 1'b0;
      err_addr <= '0;
    end
  end
`else
  logic unused_err;
  assign unused_err = err_clr ^ new_err;
  assign err_irq    = 1'b0;
  assign err_addr   = '0;
`endif

endmodule

// File: tb/tb_mem_bus_fabric.sv
// Self-checking bench for mem_bus_fabric: reset values, a vector table of
// decode/latency/timeout cases, hand sequences for abort, reset and error
// clearing, a priority check on a second overlapping-map instance, and a
// randomized stream checked against a transaction-level model.
module tb_mem_bus_fabric;
  localparam int          T   = 4;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [1:0]  slv_sel;
  logic [1:0]  slv_ready;
  logic [63:0] slv_rdata;
  logic        busy;
  logic        err_irq;
  logic [31:0] err_addr;
  logic        err_clr;

  logic        m2_valid;
  logic [31:0] m2_addr;
  logic        m2_ready;
  logic [31:0] m2_rdata;
  logic [1:0]  m2_sel;
  logic        m2_busy;
  logic        m2_irq;
  logic [31:0] m2_eaddr;

  always #5 clk = ~clk;

  mem_bus_fabric #(
    .NUM_SLAVES(2),
    .SLV_BASE({32'h8000_0000, 32'h0000_0000}),
    .SLV_MASK({32'hFFFF_FF00, 32'hFFFE_0000}),
    .TIMEOUT_CYCLES(T),
    .ERR_DATA(ERR)
  ) dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .slv_sel(slv_sel), .slv_ready(slv_ready), .slv_rdata(slv_rdata),
    .busy(busy), .err_irq(err_irq), .err_addr(err_addr), .err_clr(err_clr)
  );

  // Overlapping map: slave1 matches everything, slave0 only 0x1xxx_xxxx.
  mem_bus_fabric #(
    .NUM_SLAVES(2),
    .SLV_BASE({32'h0000_0000, 32'h1000_0000}),
    .SLV_MASK({32'h0000_0000, 32'hF000_0000}),
    .TIMEOUT_CYCLES(8),
    .ERR_DATA(ERR)
  ) dut2 (
    .clk(clk), .reset(reset), .mem_valid(m2_valid), .mem_addr(m2_addr),
    .mem_wstrb(4'h0), .mem_ready(m2_ready), .mem_rdata(m2_rdata),
    .slv_sel(m2_sel), .slv_ready(2'b11), .slv_rdata({32'h2222_2222, 32'h1111_1111}),
    .busy(m2_busy), .err_irq(m2_irq), .err_addr(m2_eaddr), .err_clr(1'b0)
  );

  int          n_pass = 0;
  int          n_total = 0;
  logic        exp_irq;
  logic [31:0] exp_eaddr;

  typedef struct {
    logic [31:0] addr;
    int          ready_at;
    logic [31:0] data;
    logic [1:0]  exp_sel;
    int          exp_lat;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic int model_decode(input logic [31:0] a);
    if ((a & 32'hFFFE_0000) == 32'h0000_0000) return 0;
    if ((a & 32'hFFFF_FF00) == 32'h8000_0000) return 1;
    return -1;
  endfunction

  // Transaction-level outcome: unmapped -> error reply 2 cycles after valid;
  // ready within the timeout window -> data on that cycle; otherwise error at T.
  task automatic model_expect(input logic [31:0] a, input int ready_at, input logic [31:0] d,
                              output logic [1:0] e_sel, output int e_lat,
                              output logic [31:0] e_rd, output bit e_err);
    int tgt;
    tgt = model_decode(a);
    if (tgt < 0) begin
      e_sel = 2'b00; e_lat = 2; e_rd = ERR; e_err = 1'b1;
    end else begin
      e_sel = 2'(1 << tgt);
      if (ready_at >= 1 && ready_at <= T) begin
        e_lat = ready_at; e_rd = d; e_err = 1'b0;
      end else begin
        e_lat = T; e_rd = ERR; e_err = 1'b1;
      end
    end
  endtask

  task automatic model_err(input logic [31:0] a, input bit clr, input bit is_err);
    if (clr) begin
      exp_irq = 1'b0; exp_eaddr = '0;
    end
`ifdef MEM_BUS_FABRIC_ERR_CAPTURE_EN
    if (is_err && !exp_irq) begin
      exp_irq = 1'b1; exp_eaddr = a;
    end
`endif
  endtask

  // Starts a request in the current cycle; returns one cycle after mem_ready.
  task automatic do_txn(input logic [31:0] a, input int ready_at, input logic [31:0] d,
                        input bit clr, output int lat, output logic [31:0] rd,
                        output logic [1:0] sel1, output bit leak);
    int tgt;
    int other;
    tgt = model_decode(a);
    mem_valid = 1'b1; mem_addr = a; mem_wstrb = 4'($urandom); err_clr = clr;
    lat = 0; rd = '0; sel1 = '0; leak = 1'b0;
    for (int cyc = 1; cyc <= 20 && lat == 0; cyc++) begin
      @(posedge clk); #1;
      err_clr = 1'b0;
      slv_rdata = {$urandom, $urandom};
      if (tgt >= 0) begin
        other = 1 - tgt;
        slv_ready = 2'b00;
        slv_ready[other] = 1'b1;
        if (ready_at != 0 && cyc >= ready_at) begin
          slv_ready[tgt] = 1'b1;
          slv_rdata[32*tgt +: 32] = d;
        end
      end else begin
        slv_ready = 2'b11;
      end
      @(negedge clk);
      if (cyc == 1) sel1 = slv_sel;
      if (mem_ready) begin
        lat = cyc; rd = mem_rdata;
      end else if (mem_rdata != 0) begin
        leak = 1'b1;
      end
    end
    @(posedge clk); #1;
    mem_valid = 1'b0; slv_ready = 2'b00;
  endtask

  task automatic run_check(input string tag, input logic [31:0] a, input int ready_at,
                           input logic [31:0] d, input bit clr, input logic [1:0] e_sel,
                           input int e_lat, input logic [31:0] e_rd, input bit e_err);
    int lat;
    logic [31:0] rd;
    logic [1:0] sel1;
    bit leak;
    do_txn(a, ready_at, d, clr, lat, rd, sel1, leak);
    chk({tag, "_sel"}, 32'(sel1), 32'(e_sel));
    chk({tag, "_lat"}, 32'(lat), 32'(e_lat));
    chk({tag, "_rdata"}, rd, e_rd);
    chk({tag, "_rdata_idle_zero"}, 32'(leak), 32'd0);
    model_err(a, clr, e_err);
    chk({tag, "_err_irq"}, 32'(err_irq), 32'(exp_irq));
    chk({tag, "_err_addr"}, err_addr, exp_eaddr);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_irq = 1'b0; exp_eaddr = '0;
  endtask

  initial begin
    logic [1:0]  e_sel;
    int          e_lat;
    logic [31:0] e_rd;
    bit          e_err;
    logic [31:0] a;
    logic [31:0] d;
    int          ra;
    bit          clr;

    vecs[0] = '{32'h8000_0004, 4, 32'h1234_5678, 2'b10, 4, 32'h1234_5678, 1'b0};
    vecs[1] = '{32'h4000_0000, 0, 32'h0,         2'b00, 2, ERR,           1'b1};
    vecs[2] = '{32'h0000_0100, 0, 32'h0,         2'b01, 4, ERR,           1'b1};
    vecs[3] = '{32'h0000_0100, 4, 32'hAAAA_5555, 2'b01, 4, 32'hAAAA_5555, 1'b0};
    vecs[4] = '{32'h5000_0000, 0, 32'h0,         2'b00, 2, ERR,           1'b1};
    vecs[5] = '{32'h8000_00FC, 1, 32'h0BAD_F00D, 2'b10, 1, 32'h0BAD_F00D, 1'b0};
    vecs[6] = '{32'h0001_FFFC, 2, 32'h600D_CAFE, 2'b01, 2, 32'h600D_CAFE, 1'b0};
    vecs[7] = '{32'h0002_0000, 1, 32'h0,         2'b00, 2, ERR,           1'b1};
    vecs[8] = '{32'h8000_0100, 1, 32'h0,         2'b00, 2, ERR,           1'b1};

    mem_valid = 1'b0; mem_addr = '0; mem_wstrb = '0; slv_ready = '0; slv_rdata = '0;
    err_clr = 1'b0; m2_valid = 1'b0; m2_addr = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_ready", 32'(mem_ready), 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    chk("rst_slv_sel", 32'(slv_sel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err_irq", 32'(err_irq), 32'd0);
    chk("rst_err_addr", err_addr, 32'd0);
    reset = 1'b0;
    exp_irq = 1'b0; exp_eaddr = '0;
    @(posedge clk); #1;

    // Vector table, applied back to back.
    for (int i = 0; i < 9; i++)
      run_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].ready_at, vecs[i].data, 1'b0,
                vecs[i].exp_sel, vecs[i].exp_lat, vecs[i].exp_rd, vecs[i].exp_err);

    // Lone err_clr pulse.
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    model_err('0, 1'b1, 1'b0);
    chk("clr_err_irq", 32'(err_irq), 32'(exp_irq));
    chk("clr_err_addr", err_addr, exp_eaddr);

    // Ready on the timeout cycle after a clear: data, no error.
    model_expect(32'h0000_0040, T, 32'hAAAA_5555, e_sel, e_lat, e_rd, e_err);
    run_check("tmo_edge", 32'h0000_0040, T, 32'hAAAA_5555, 1'b0, e_sel, e_lat, e_rd, e_err);

    // First error, then a new error with a coincident clear.
    run_check("err_first", 32'h4000_0000, 0, '0, 1'b0, 2'b00, 2, ERR, 1'b1);
    run_check("err_clr_coinc", 32'h5000_0000, 0, '0, 1'b1, 2'b00, 2, ERR, 1'b1);

    // mem_valid drops in the second access cycle while the slave turns ready.
    mem_valid = 1'b1; mem_addr = 32'h0000_0010;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_valid = 1'b0; slv_ready = 2'b01; slv_rdata = {32'h0, 32'h7777_7777};
    @(negedge clk);
    chk("abort_no_ready", 32'(mem_ready), 32'd0);
    @(posedge clk); #1;
    slv_ready = 2'b00;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sel", 32'(slv_sel), 32'd0);
    chk("abort_err_irq", 32'(err_irq), 32'(exp_irq));

    // Reset two cycles into an access, with the slave ready in the reset cycle.
    mem_valid = 1'b1; mem_addr = 32'h0000_0020;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1; slv_ready = 2'b01;
    @(negedge clk);
    chk("rst_acc_no_ready", 32'(mem_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; mem_valid = 1'b0; slv_ready = 2'b00;
    exp_irq = 1'b0; exp_eaddr = '0;
    chk("rst_acc_sel", 32'(slv_sel), 32'd0);
    chk("rst_acc_busy", 32'(busy), 32'd0);
    chk("rst_acc_ready", 32'(mem_ready), 32'd0);
    chk("rst_acc_err_irq", 32'(err_irq), 32'd0);
    @(posedge clk); #1;
    run_check("post_rst", 32'h8000_0000, 2, 32'hC0FF_EE00, 1'b0, 2'b10, 2, 32'hC0FF_EE00, 1'b0);

    // Reset on the cycle an error reply would be given.
    mem_valid = 1'b1; mem_addr = 32'h6000_0000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_err_no_ready", 32'(mem_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; mem_valid = 1'b0;
    exp_irq = 1'b0; exp_eaddr = '0;
    chk("rst_err_busy", 32'(busy), 32'd0);
    chk("rst_err_irq", 32'(err_irq), 32'd0);
    @(posedge clk); #1;

    // Overlapping map: lowest index wins.
    m2_valid = 1'b1; m2_addr = 32'h1000_0004;
    @(posedge clk); #1;
    chk("prio_sel_low", 32'(m2_sel), 32'h1);
    chk("prio_rdata_low", m2_rdata, 32'h1111_1111);
    @(posedge clk); #1;
    m2_addr = 32'h2000_0000;
    @(posedge clk); #1;
    chk("prio_sel_high", 32'(m2_sel), 32'h2);
    chk("prio_rdata_high", m2_rdata, 32'h2222_2222);
    @(posedge clk); #1;
    m2_valid = 1'b0;

    // Randomized stream against the transaction model.
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 2))
        0:       a = $urandom & 32'h0001_FFFF;
        1:       a = 32'h8000_0000 | ($urandom & 32'h0000_00FF);
        default: a = $urandom;
      endcase
      ra  = $urandom_range(0, 6);
      d   = $urandom;
      clr = ($urandom_range(0, 4) == 0);
      model_expect(a, ra, d, e_sel, e_lat, e_rd, e_err);
      run_check($sformatf("rnd%0d", k), a, ra, d, clr, e_sel, e_lat, e_rd, e_err);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_bus_fabric.md
MEM_BUS_FABRIC -- requirements
Module: mem_bus_fabric

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 8, number of slave ports (1..16).
REQ-002 SHALL have parameter SLV_BASE, default 0, flat NUM_SLAVES*32-bit vector of slave base addresses; slave i occupies bits [32*i+31:32*i].
REQ-003 SHALL have parameter SLV_MASK, default 0, flat NUM_SLAVES*32-bit vector of decode masks, same slicing as SLV_BASE.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum ACCESS cycles before forced error response (1..65535).
REQ-005 SHALL have parameter ERR_DATA, default 32'hDEAD_BEEF, read data returned on any error response.
REQ-006 SHALL have ports: clk  in  1  system clock.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 mem_valid  in  1  CPU request valid, held until mem_ready.
REQ-009 mem_addr  in  32  CPU byte address.
REQ-010 mem_wstrb  in  4  CPU write strobes, non-zero = write.
REQ-011 mem_ready  out  1  transfer complete, one-cycle pulse.
REQ-012 mem_rdata  out  32  read data to CPU.
REQ-013 slv_sel  out  NUM_SLAVES  one-hot registered slave select.
REQ-014 slv_ready  in  NUM_SLAVES  per-slave ready.
REQ-015 slv_rdata  in  NUM_SLAVES*32  per-slave read data, flat, same slicing as SLV_BASE.
REQ-016 busy  out  1  high whenever state is not IDLE.
REQ-017 err_irq  out  1  sticky bus-error interrupt.
REQ-018 err_addr  out  32  address of first uncleared error.
REQ-019 err_clr  in  1  clears err_irq and err_addr.
REQ-020 Address, write data and wstrb SHALL be wired to slaves outside this block; the fabric handles only select, ready and read data.

Function
REQ-021 Slave i SHALL match when (mem_addr & mask_i) == base_i; on overlapping matches the lowest index SHALL win.
REQ-022 FSM states SHALL be IDLE, ACCESS, ERR_RESP.
REQ-023 IDLE with mem_valid and a match -> ACCESS next cycle, slv_sel one-hot for winning index; select latency exactly 1 cycle from mem_valid.
REQ-024 IDLE with mem_valid and no match -> ERR_RESP; ERR_RESP asserts mem_ready with mem_rdata = ERR_DATA for exactly one cycle, then IDLE.
REQ-025 In ACCESS, mem_ready SHALL equal slv_ready of the selected slave, combinationally, with mem_rdata = that slave's slv_rdata in the same cycle; on ready, slv_sel clears and state -> IDLE.
REQ-026 ACCESS SHALL run a cycle counter from 1; if it reaches TIMEOUT_CYCLES without ready, fabric SHALL assert mem_ready with ERR_DATA that cycle, clear slv_sel, return to IDLE.
REQ-027 Ready arriving in the same cycle the counter reaches TIMEOUT_CYCLES SHALL be a normal completion with slave data, no error.
REQ-028 mem_valid dropping while in ACCESS SHALL abort to IDLE next cycle: no mem_ready, no error.
REQ-029 Back-to-back: a new mem_valid in the cycle after mem_ready SHALL be accepted from IDLE normally.
REQ-030 slv_ready of non-selected slaves SHALL be ignored; mem_rdata SHALL be 0 when mem_ready is low.
REQ-031 Counter SHALL be wide enough for TIMEOUT_CYCLES and SHALL never wrap.

Reset
REQ-032 On reset: state IDLE, slv_sel 0, mem_ready 0, mem_rdata 0, busy 0, counter 0, err_irq 0, err_addr 0.
REQ-033 Reset mid-ACCESS or mid-ERR_RESP SHALL abort without issuing mem_ready.

Configuration
REQ-034 Macro MEM_BUS_FABRIC_ERR_CAPTURE_EN defined: unmapped access or timeout SHALL set err_irq and latch mem_addr into err_addr unless err_irq already set; err_clr clears both next cycle; err_clr coincident with a new error SHALL leave the new error latched.
REQ-035 Macro undefined: err_irq and err_addr SHALL be constant 0, err_clr ignored; error responses per REQ-024/026 unchanged.

Verification
REQ-036 NUM_SLAVES=2, base0=0x0000_0000 mask0=0xFFFE_0000, base1=0x8000_0000 mask1=0xFFFF_FF00; read 0x8000_0004, slave1 ready 3 cycles after select with 0x1234_5678 -> slv_sel=2'b10 one cycle after valid, mem_ready pulse with rdata 0x1234_5678.
REQ-037 Read 0x4000_0000 -> mem_ready 2 cycles after valid, rdata 0xDEAD_BEEF, err_irq=1, err_addr=0x4000_0000 (macro defined).
REQ-038 TIMEOUT_CYCLES=4, slave0 never ready, read 0x100 -> mem_ready on 4th ACCESS cycle with 0xDEAD_BEEF, slv_sel back to 0.
REQ-039 TIMEOUT_CYCLES=4, slave0 ready on 4th ACCESS cycle with 0xAAAA_5555 -> rdata 0xAAAA_5555, err_irq stays 0.
REQ-040 Reset asserted 2 cycles into ACCESS -> next cycle slv_sel=0, busy=0, no mem_ready; subsequent read to 0x8000_0000 completes normally.
REQ-041 Second unmapped read 0x5000_0000 while err_irq set -> err_addr stays 0x4000_0000; pulse err_clr -> err_irq=0, err_addr=0.
